gpu_prog_loader: RTL

Host-side program loader that sits directly upstream of the `gpu` top. It accepts a stream of 16-bit instruction/data words from the host over a valid/ready handshake and assembles them into the 1024-entry frame image. It then drives `data_frames_in` and pulses `prog_loading` to start the scheduler, and holds the image stable until all 16 cores report completion.

---
 rtl/gpu_pkg.sv | 27 ++
 rtl/loader_frame_store.sv | 43 ++++
 rtl/gpu_prog_loader.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// ---------------------------------------------------------------------------
// gpu_pkg
// Shared constants and types for the GPU front end and its program loader.
//   FRAMES         frame-store depth (equals the gpu frame count)
//   WORD_W         width of one frame word
//   NUM_CORES      number of gpu cores reporting ready
//   FRAME_AW       frame address width
//   COUNT_W        load counter width (must hold the value FRAMES)
//   loader_state_e program loader FSM states
// ---------------------------------------------------------------------------
package gpu_pkg;

    localparam int FRAMES    = 1024;
    localparam int WORD_W    = 16;
    localparam int NUM_CORES = 16;
    localparam int FRAME_AW  = $clog2(FRAMES);
    localparam int COUNT_W   = FRAME_AW + 1;

    typedef enum logic [2:0] {
        LD_IDLE      = 3'd0,
        LD_FILL      = 3'd1,
        LD_LAUNCH    = 3'd2,
        LD_WAIT_BUSY = 3'd3,
        LD_WAIT_DONE = 3'd4
    } loader_state_e;

endpackage

// File: rtl/loader_frame_store.sv
// ---------------------------------------------------------------------------
// loader_frame_store
// Registered FRAMES x WORD_W program image with one write port. Entries at
// or above the current fill count read as zero, so a new program never needs
// the old image cleared.
// Ports:
//   clk       rising-edge clock
//   we_i      write enable
//   waddr_i   write address
//   wdata_i   write data
//   count_i   number of valid entries (0..FRAMES)
//   frames_o  masked image, frames_o[k] = store[k] when k < count_i, else 0
// ---------------------------------------------------------------------------
module loader_frame_store
    import gpu_pkg::*;
(
    input  logic                             clk,
    input  logic                             we_i,
    input  logic [FRAME_AW-1:0]              waddr_i,
    input  logic [WORD_W-1:0]                wdata_i,
    input  logic [COUNT_W-1:0]               count_i,
    output logic [FRAMES-1:0][WORD_W-1:0]    frames_o
);

    // No reset on the array: the count mask hides stale contents.
    logic [WORD_W-1:0] mem_q [FRAMES];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        frames_o = '0;
        for (int k = 0; k < FRAMES; k++) begin
            if (COUNT_W'(k) < count_i) begin
                frames_o[k] = mem_q[k];
            end
        end
    end

endmodule

// File: rtl/gpu_prog_loader.sv
// ---------------------------------------------------------------------------
// gpu_prog_loader
// Collects host words into the frame image, launches the scheduler with a
// one-cycle strobe and holds the image until every core is ready again.
// Optional feature macro: GPU_LOADER_CHECKSUM_EN (16-bit modular checksum of
// the accepted words; a non-zero sum aborts the launch and sets chk_err).
// Handshake: a word moves when host_valid && host_ready at a rising edge;
// with host_ready low the host holds its word unchanged.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   host_valid/ready host word handshake; host_data word, host_last end mark
//   core_ready       per-core ready from the gpu cores
//   prog_loading     one-cycle launch strobe
//   data_frames_in   frame image to the scheduler
//   load_count       words accepted for the current program (0..FRAMES)
//   busy             high in LAUNCH, WAIT_BUSY, WAIT_DONE
//   ovf_err          sticky overflow flag (word after FRAMES without last)
//   chk_err          sticky checksum flag (only with GPU_LOADER_CHECKSUM_EN)
//   dbg_state        current FSM state
// ---------------------------------------------------------------------------
module gpu_prog_loader
    import gpu_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             host_valid,
    output logic                             host_ready,
    input  logic [WORD_W-1:0]                host_data,
    input  logic                             host_last,
    input  logic [NUM_CORES-1:0]             core_ready,
    output logic                             prog_loading,
    output logic [FRAMES-1:0][WORD_W-1:0]    data_frames_in,
    output logic [COUNT_W-1:0]               load_count,
    output logic                             busy,
    output logic                             ovf_err,
`ifdef GPU_LOADER_CHECKSUM_EN
    output logic                             chk_err,
`endif
    output loader_state_e                    dbg_state
);

    loader_state_e        state_q;
    logic [COUNT_W-1:0]   count_q;
    logic                 ready_q;
    logic                 launch_q;
    logic                 busy_q;
    logic                 ovf_q;

    logic                 accept;
    logic                 drop;
    logic                 we;
    logic                 done;
    logic                 sum_ok;
    logic [FRAME_AW-1:0]  waddr;

    assign accept = host_valid & ready_q;
    // A word offered in FILL with the store already full is consumed but dropped.
    assign drop   = accept && (state_q == LD_FILL) && (count_q == COUNT_W'(FRAMES));
    assign we     = accept && !drop;
    assign waddr  = (state_q == LD_IDLE) ? '0 : count_q[FRAME_AW-1:0];
    assign done   = accept && (host_last || drop);

`ifdef GPU_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q;
    logic [WORD_W-1:0] sum_d;
    logic              chk_q;

    always_comb begin
        sum_d = sum_q;
        if (state_q == LD_IDLE) begin
            sum_d = host_data;
        end else if (!drop) begin
            sum_d = sum_q + host_data;
        end
    end

    assign sum_ok = (sum_d == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
            chk_q <= 1'b0;
        end else if (accept) begin
            sum_q <= sum_d;
            if (state_q == LD_IDLE) begin
                chk_q <= 1'b0;
            end
            if (done && !sum_ok) begin
                chk_q <= 1'b1;
            end
        end
    end

    assign chk_err = chk_q;
`else
    assign sum_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= LD_IDLE;
            count_q  <= '0;
            ready_q  <= 1'b0;
            launch_q <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            launch_q <= 1'b0;
            case (state_q)
                LD_IDLE, LD_FILL: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (state_q == LD_IDLE) begin
                            count_q <= COUNT_W'(1);
                            ovf_q   <= 1'b0;
                        end else if (drop) begin
                            ovf_q   <= 1'b1;
                        end else begin
                            count_q <= count_q + COUNT_W'(1);
                        end
                        if (done) begin
                            if (sum_ok) begin
                                state_q  <= LD_LAUNCH;
                                launch_q <= 1'b1;
                                busy_q   <= 1'b1;
                                ready_q  <= 1'b0;
                            end else begin
                                state_q  <= LD_IDLE;
                            end
                        end else begin
                            state_q <= LD_FILL;
                        end
                    end
                end
                LD_LAUNCH: begin
                    state_q <= LD_WAIT_BUSY;
                end
                LD_WAIT_BUSY: begin
                    // Cores have picked up work once any of them drops ready.
                    if (core_ready != '1) begin
                        state_q <= LD_WAIT_DONE;
                    end
                end
                LD_WAIT_DONE: begin
                    if (core_ready == '1) begin
                        state_q <= LD_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= LD_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    loader_frame_store u_store (
        .clk      (clk),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (host_data),
        .count_i  (count_q),
        .frames_o (data_frames_in)
    );

    assign host_ready   = ready_q;
    assign prog_loading = launch_q;
    assign load_count   = count_q;
    assign busy         = busy_q;
    assign ovf_err      = ovf_q;
    assign dbg_state    = state_q;

endmodule
